// File: rtl/sc_hex_display.sv
// sc_hex_display: binary to six-digit seven-segment driver.
// Uses a serial double-dabble converter and a one-deep pending buffer, so the
// most recently written value is always the one that ends up displayed.
// Optional feature macro: HEX_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module sc_hex_display #(
    parameter int unsigned VALUE_W = 20,
    parameter int unsigned DIGITS  = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [VALUE_W-1:0]    value,
    output logic [7*DIGITS-1:0]   io_out_hex,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned HEX_W = 7 * DIGITS;
    localparam int unsigned CNT_W = $clog2(VALUE_W + 1);

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // 10**n in 64 bits; the smallest value that no longer fits on the display
    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam logic [63:0] OVF_LIM = pow10(DIGITS);

    // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [VALUE_W-1:0] shift_q, shift_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               pending_q, pending_d;
    logic [VALUE_W-1:0] pval_q, pval_d;
    logic [HEX_W-1:0]   hex_d;
    logic [HEX_W-1:0]   hex_dec;
    logic               busy_d;
    logic               done_d;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load || pending_q) state_d = CONV;
            CONV:    if (cnt_q == CNT_W'(VALUE_W - 1)) state_d = UPDATE;
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Per-nibble +3 adjust ahead of each shift (no inter-nibble carry)
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // Segment decode of the finished BCD result, with overflow dashes
    always_comb begin
        logic [3:0] nib;
`ifdef HEX_LEADING_ZERO_BLANK_EN
        logic       nz_seen;
        nz_seen = 1'b0;
`endif
        nib     = 4'd0;
        hex_dec = '1;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            nib = bcd_q[4*k +: 4];
`ifdef HEX_LEADING_ZERO_BLANK_EN
            if (nib != 4'd0) nz_seen = 1'b1;
`endif
            if (ovf_q) begin
                hex_dec[7*k +: 7] = SEG_DASH;
`ifdef HEX_LEADING_ZERO_BLANK_EN
            end else if (!nz_seen && (k != 0)) begin
                hex_dec[7*k +: 7] = SEG_BLANK;
`endif
            end else begin
                hex_dec[7*k +: 7] = seg_decode(nib);
            end
        end
    end

    // Output / datapath next values
    always_comb begin
        shift_d   = shift_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        pending_d = pending_q;
        pval_d    = pval_q;
        hex_d     = io_out_hex;
        done_d    = 1'b0;
        busy_d    = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (load) begin
                    // a fresh write supersedes anything still pending
                    shift_d   = value;
                    bcd_d     = '0;
                    cnt_d     = '0;
                    ovf_d     = (64'(value) >= OVF_LIM);
                    pending_d = 1'b0;
                end else if (pending_q) begin
                    shift_d   = pval_q;
                    bcd_d     = '0;
                    cnt_d     = '0;
                    ovf_d     = (64'(pval_q) >= OVF_LIM);
                    pending_d = 1'b0;
                end
            end
            CONV: begin
                bcd_d   = {bcd_adj[BCD_W-2:0], shift_q[VALUE_W-1]};
                shift_d = {shift_q[VALUE_W-2:0], 1'b0};
                cnt_d   = cnt_q + CNT_W'(1);
                if (load) begin
                    pending_d = 1'b1;
                    pval_d    = value;
                end
            end
            UPDATE: begin
                hex_d  = hex_dec;
                done_d = 1'b1;
                if (load) begin
                    pending_d = 1'b1;
                    pval_d    = value;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            pending_q  <= 1'b0;
            pval_q     <= '0;
            io_out_hex <= '1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            pending_q  <= pending_d;
            pval_q     <= pval_d;
            io_out_hex <= hex_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

endmodule

// File: tb/tb_sc_hex_display.sv
// Testbench for sc_hex_display: table of directed conversions plus
// hand-written pending-buffer and reset sequences.
module tb_sc_hex_display;

    logic        clock;
    logic        reset;
    logic        load;
    logic [19:0] value;
    logic [41:0] io_out_hex;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    sc_hex_display #(.VALUE_W(20), .DIGITS(6)) dut (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .value      (value),
        .io_out_hex (io_out_hex),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // digit codes: 0..9 digits, A = blank, B = dash
    typedef struct {
        logic [19:0] val;
        logic [23:0] digs;
        string       name;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [6:0] seg(input logic [3:0] c);
        case (c)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hB: return 7'b0111111;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [41:0] mk_hex(input logic [23:0] digs);
        logic [41:0] h;
        h = '1;
        for (int k = 0; k < 6; k++) begin
            h[7*k +: 7] = seg(digs[4*k +: 4]);
        end
        return h;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one load from IDLE and follow the conversion to its done pulse
    task automatic run_conv(input logic [19:0] v, input logic [23:0] digs, input string nm);
        logic [41:0] exp_hex;
        logic [41:0] prev;
        int          n;
        bit          got;
        exp_hex = mk_hex(digs);
        prev    = io_out_hex;
        load    = 1'b1;
        value   = v;
        tick();
        load    = 1'b0;
        chk({nm, " busy_rise"}, 64'(busy), 64'd1);
        n   = 0;
        got = 1'b0;
        while (!got && n < 30) begin
            tick();
            n++;
            if (n == 10) chk({nm, " hex_hold"}, 64'(io_out_hex), 64'(prev));
            if (done) got = 1'b1;
        end
        chk({nm, " latency"}, 64'(n), 64'd21);
        chk({nm, " hex"}, 64'(io_out_hex), 64'(exp_hex));
        chk({nm, " busy_fall"}, 64'(busy), 64'd0);
        tick();
        chk({nm, " done_one_cycle"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [41:0] exp42;
        logic [41:0] exp9;
        int          n;
        int          act_cnt;
        bit          got;

        vecs[0] = '{20'd123456,  24'h123456, "v123456"};
        vecs[1] = '{20'd1000000, 24'hBBBBBB, "ovf1000000"};
        vecs[2] = '{20'd999999,  24'h999999, "v999999"};
        vecs[3] = '{20'd1048575, 24'hBBBBBB, "ovf_max"};
        vecs[4] = '{20'd100000,  24'h100000, "v100000"};
`ifdef HEX_LEADING_ZERO_BLANK_EN
        vecs[5] = '{20'd305,     24'hAAA305, "v305"};
        vecs[6] = '{20'd0,       24'hAAAAA0, "v0"};
        vecs[7] = '{20'd7,       24'hAAAAA7, "v7"};
        exp42   = mk_hex(24'hAAAA42);
        exp9    = mk_hex(24'hAAAAA9);
`else
        vecs[5] = '{20'd305,     24'h000305, "v305"};
        vecs[6] = '{20'd0,       24'h000000, "v0"};
        vecs[7] = '{20'd7,       24'h000007, "v7"};
        exp42   = mk_hex(24'h000042);
        exp9    = mk_hex(24'h000009);
`endif

        reset = 1'b1;
        load  = 1'b0;
        value = '0;
        tick();
        tick();
        chk("reset hex", 64'(io_out_hex), 64'h3FF_FFFF_FFFF);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_conv(vecs[i].val, vecs[i].digs, vecs[i].name);
        end

        // Pending buffer: 42 converting, 7 then 9 arrive; only 9 follows
        load  = 1'b1;
        value = 20'd42;
        tick();
        for (int e = 1; e <= 21; e++) begin
            if (e == 5) begin
                load  = 1'b1;
                value = 20'd7;
            end else if (e == 12) begin
                load  = 1'b1;
                value = 20'd9;
            end else begin
                load  = 1'b0;
            end
            tick();
        end
        load = 1'b0;
        chk("pend first_done", 64'(done), 64'd1);
        chk("pend first_hex", 64'(io_out_hex), 64'(exp42));
        chk("pend busy_gap", 64'(busy), 64'd0);
        tick();
        chk("pend busy_restart", 64'(busy), 64'd1);
        chk("pend done_cleared", 64'(done), 64'd0);
        n   = 0;
        got = 1'b0;
        while (!got && n < 30) begin
            tick();
            n++;
            if (done) got = 1'b1;
        end
        chk("pend second_latency", 64'(n), 64'd21);
        chk("pend second_hex", 64'(io_out_hex), 64'(exp9));
        repeat (5) tick();
        chk("pend no_third", 64'(busy), 64'd0);
        chk("pend hex_stays", 64'(io_out_hex), 64'(exp9));

        // Reset mid-conversion drops the conversion and the queued load
        load  = 1'b1;
        value = 20'd555555;
        tick();
        for (int e = 1; e <= 10; e++) begin
            load  = (e == 5);
            value = 20'd111;
            reset = (e == 10);
            tick();
        end
        load = 1'b0;
        chk("rstmid hex", 64'(io_out_hex), 64'h3FF_FFFF_FFFF);
        chk("rstmid busy", 64'(busy), 64'd0);
        chk("rstmid done", 64'(done), 64'd0);
        reset   = 1'b0;
        act_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (busy || done) act_cnt++;
        end
        chk("rstmid no_activity", 64'(act_cnt), 64'd0);

        // Simultaneous load and reset: reset wins
        reset = 1'b1;
        load  = 1'b1;
        value = 20'd5;
        tick();
        reset = 1'b0;
        load  = 1'b0;
        chk("rst_load busy", 64'(busy), 64'd0);
        tick();
        chk("rst_load still_idle", 64'(busy), 64'd0);
        chk("rst_load hex", 64'(io_out_hex), 64'h3FF_FFFF_FFFF);

        run_conv(vecs[0].val, vecs[0].digs, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sc_hex_display.md
# sc_hex_display

Sequential binary-to-seven-segment display driver that consumes the value the data-memory I/O space writes for the hex displays. It converts a binary value to decimal with a multi-cycle double-dabble engine and registers active-low segment patterns for six DE-board digits. It has a one-deep pending buffer, so a CPU store never stalls and the last value written is always displayed.

## Interface
- VALUE_W, 20: width of the binary input value.
- DIGITS, 6: number of decimal digits driven.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  one-cycle strobe: capture `value` for display.
- value  in  VALUE_W  unsigned binary value to display.
- io_out_hex  out  7*DIGITS (42)  segment patterns. Digit k is in bits [7k+6:7k], and digit 0 is the ones digit. Bit order is {g,f,e,d,c,b,a}, active-low.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse in the cycle after io_out_hex updates.

## Operation
- States:
  - IDLE: waiting for work.
  - CONV: VALUE_W shift cycles.
  - UPDATE: one cycle that decodes and writes io_out_hex.
- IDLE to CONV:
  - The transition occurs when `load` is high or `pending` is set.
  - `load` has priority and its `value` is used; otherwise the pending value is used and `pending` is cleared.
  - On this edge the shift register takes the value, the BCD register (4*DIGITS bits) clears, the bit counter clears, and `ovf` is set if the value is at least 10^DIGITS.
- CONV, each cycle:
  - Every BCD nibble at or above 5 gets +3.
  - Then {bcd, shift} shifts left by 1 and the counter increments.
  - After exactly VALUE_W shifts the state goes to UPDATE.
- UPDATE:
  - Each BCD nibble is decoded: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - If `ovf` is set, every digit shows dash 0111111 instead.
  - io_out_hex is registered, and the state returns to IDLE.
- Pending buffer:
  - A `load` while the state is CONV or UPDATE stores `value` in the pending register and sets `pending`.
  - A further load overwrites it (last write wins). Intermediate values are dropped, never queued.
- Width rules:
  - The BCD register is 4*DIGITS bits, and the +3 adjust works per nibble without carry.
  - Overflow values still take the full VALUE_W cycles, so latency is uniform.
- Reset:
  - io_out_hex is all ones (all blank, 42'h3FF_FFFF_FFFF); busy=0, done=0, pending=0, state IDLE.
  - Reset during CONV or UPDATE aborts the conversion with no done pulse, drops any pending value and blanks the display.

## Timing
- Load edge E0 goes to CONV, and busy=1 from the cycle after E0.
- Shifts happen on edges E1..E(VALUE_W); for the default, E1..E20.
- Edge E(VALUE_W+1), E21 for the default, writes io_out_hex, pulses done=1 for one cycle and drops busy to 0.
- Latency from the load edge to a valid display is VALUE_W+1 cycles, 21 for the default.
- If pending is set, the next conversion starts on the edge after E21: busy=0 for exactly one cycle, then busy=1.
- A `load` in the IDLE cycle right after done starts immediately and pending is ignored.
- Simultaneous `load` and `reset`: reset wins.
- io_out_hex changes only on UPDATE edges or on reset, so it is glitch-free between conversions.

## Configuration
- HEX_LEADING_ZERO_BLANK_EN:
  - When defined, zero digits above the most significant non-zero digit show blank (1111111) at UPDATE.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
  - Overflow dashes are unaffected.
- When not defined, all DIGITS digits are shown, including leading zeros.

## Test plan
- Reset: assert reset for 2 cycles -> io_out_hex=42'h3FF_FFFF_FFFF, busy=0, done=0.
- Basic conversion: load value=123456 -> busy rises the cycle after load; 21 cycles after the load edge, digits 5..0 = 1111001, 0100100, 0110000, 0011001, 0010010, 0000010; done is high for exactly 1 cycle.
- Overflow: load value=1000000 -> after 21 cycles every digit = 0111111.
- Pending buffer: load 42, then load 7 at shift 5 and load 9 at shift 12 -> display shows 42 with done, busy=0 for 1 cycle, then 9 appears 21 cycles later; 7 is never displayed.
- Leading-zero blanking, value=305:
  - With the macro: digits 2..0 = 0110000, 1000000, 0010010 and digits 5..3 = 1111111.
  - Without the macro: digits 5..3 = 1000000.
  - Value 0 with the macro: only digit 0 = 1000000.
- Reset mid-conversion: load 555555, assert reset at shift 10 -> io_out_hex blank, busy=0, no done pulse; a load queued before the reset is not converted afterwards.
